// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences the shared-ALU datapath for
// addi/add/sub/beq/jal/lw/sw, with a timed req/ready memory handshake.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        alu_op,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        illegal,
   output logic        bus_err,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_ALU = 4'd2,
      WB_ALU   = 4'd3,
      EXEC_BR  = 4'd4,
      EXEC_JAL = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      MEM_WR   = 4'd8,
      WB_MEM   = 4'd9,
      TRAP     = 4'd15
   } st_t;

   localparam bit             TMO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

   st_t              st, st_nx;
   logic [CNT_W-1:0] cnt;
   logic             ill_q, berr_q, ill_set, berr_set;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];

   logic unused_instr;
   assign unused_instr = ^{instr[24:15], instr[11:7]};

   logic is_opi, is_opr, is_ld, is_st, dec_alu, dec_br, dec_jal, dec_mem;
   assign is_opi  = (op == 7'b0010011);
   assign is_opr  = (op == 7'b0110011);
   assign is_ld   = (op == 7'b0000011);
   assign is_st   = (op == 7'b0100011);
   assign dec_alu = (is_opi && f3 == 3'b000) ||
                    (is_opr && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000));
   assign dec_br  = (op == 7'b1100011) && (f3 == 3'b000);
   assign dec_jal = (op == 7'b1101111);
   assign dec_mem = (is_ld || is_st) && (f3 == 3'b010);

   // Waiting is derived from state directly so the timeout path has no
   // dependency on the request output it guards.
   logic mem_wait, tmo_hit;
   assign mem_wait = (st == FETCH || st == MEM_RD || st == MEM_WR) && !mem_ready;
   assign tmo_hit  = TMO_EN && mem_wait && (cnt == TMO_LAST);

   logic       c_mreq, c_mwe, c_iord, c_irwe, c_pcwe, c_pcsrc, c_aop, c_rwe, c_ret;
   logic [1:0] c_sa, c_sb, c_wb;

   always_comb begin
      st_nx    = st;
      ill_set  = 1'b0;
      berr_set = 1'b0;
      c_mreq   = 1'b0;
      c_mwe    = 1'b0;
      c_iord   = 1'b0;
      c_irwe   = 1'b0;
      c_pcwe   = 1'b0;
      c_pcsrc  = 1'b0;
      c_aop    = 1'b0;
      c_rwe    = 1'b0;
      c_ret    = 1'b0;
      c_sa     = 2'd0;
      c_sb     = 2'd0;
      c_wb     = 2'd0;
      case (st)
         FETCH: begin
            c_mreq = 1'b1;
            c_sb   = 2'd1;
            if (mem_ready) begin
               c_irwe = 1'b1;
               c_pcwe = 1'b1;
               st_nx  = DECODE;
            end else if (tmo_hit) begin
               st_nx    = TRAP;
               berr_set = 1'b1;
            end
         end
         DECODE: begin
            c_sa = 2'd1;
            c_sb = 2'd3;
            if (dec_alu)      st_nx = EXEC_ALU;
            else if (dec_br)  st_nx = EXEC_BR;
            else if (dec_jal) st_nx = EXEC_JAL;
            else if (dec_mem) st_nx = MEM_ADDR;
            else begin
               st_nx   = TRAP;
               ill_set = 1'b1;
            end
         end
         EXEC_ALU: begin
            c_sa  = 2'd2;
            c_sb  = is_opi ? 2'd2 : 2'd0;
            c_aop = is_opr && instr[30];
            st_nx = WB_ALU;
         end
         WB_ALU: begin
            c_rwe = 1'b1;
            c_ret = 1'b1;
            st_nx = FETCH;
         end
         EXEC_BR: begin
            c_sa    = 2'd2;
            c_aop   = 1'b1;
            c_pcwe  = zero;
            c_pcsrc = zero;
            c_ret   = 1'b1;
            st_nx   = FETCH;
         end
         EXEC_JAL: begin
            c_rwe   = 1'b1;
            c_wb    = 2'd2;
            c_pcwe  = 1'b1;
            c_pcsrc = 1'b1;
            c_ret   = 1'b1;
            st_nx   = FETCH;
         end
         MEM_ADDR: begin
            c_sa  = 2'd2;
            c_sb  = 2'd2;
            st_nx = is_ld ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            c_mreq = 1'b1;
            c_iord = 1'b1;
            if (mem_ready) st_nx = WB_MEM;
            else if (tmo_hit) begin
               st_nx    = TRAP;
               berr_set = 1'b1;
            end
         end
         MEM_WR: begin
            c_mreq = 1'b1;
            c_mwe  = 1'b1;
            c_iord = 1'b1;
            if (mem_ready) begin
               c_ret = 1'b1;
               st_nx = FETCH;
            end else if (tmo_hit) begin
               st_nx    = TRAP;
               berr_set = 1'b1;
            end
         end
         WB_MEM: begin
            c_rwe = 1'b1;
            c_wb  = 2'd1;
            c_ret = 1'b1;
            st_nx = FETCH;
         end
         TRAP:    st_nx = TRAP;
         default: st_nx = TRAP;
      endcase
   end

   // Gate with rstn so FETCH cannot raise ir_we/pc_we/mem_req during reset.
   assign {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_we, wb_sel, retire} =
          rstn ? {c_mreq, c_mwe, c_iord, c_irwe, c_pcwe, c_pcsrc, c_sa, c_sb,
                  c_aop, c_rwe, c_wb, c_ret} : 15'd0;

   assign illegal = ill_q;
   assign bus_err = berr_q;
   assign state   = st;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st     <= FETCH;
         cnt    <= '0;
         ill_q  <= 1'b0;
         berr_q <= 1'b0;
      end else begin
         st     <= st_nx;
         cnt    <= mem_wait ? cnt + 1'b1 : '0;
         ill_q  <= ill_q | ill_set;
         berr_q <= berr_q | berr_set;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: a per-instruction phase-list model predicts
// state, control outputs, sticky flags and retire latency every cycle.
module tb_mc_ctrl_fsm;

   localparam int TMO = 16;

   logic        clk, rstn, zero, mem_ready;
   logic [31:0] instr;
   logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_op, reg_we, retire;
   logic        illegal, bus_err;
   logic [1:0]  alu_src_a, alu_src_b, wb_sel;
   logic [3:0]  state;
   logic [14:0] ctl;

   mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .illegal(illegal),
      .bus_err(bus_err), .state(state)
   );

   assign ctl = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_we, wb_sel, retire};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Model: each instruction class is a list of phases (state codes).
   // Classes: 0 alu, 1 beq, 2 jal, 3 lw, 4 sw, 5 illegal.
   int sq [5][5] = '{'{0,1,2,3,0}, '{0,1,4,0,0}, '{0,1,5,0,0}, '{0,1,6,7,9}, '{0,1,6,8,0}};
   int ln [5]    = '{4, 3, 3, 5, 4};
   int m_step, m_wait;
   bit m_trap, m_ill, m_berr;

   function automatic int cls_of(logic [31:0] ins);
      logic [6:0] o;
      logic [2:0] f;
      logic [6:0] f7;
      o = ins[6:0]; f = ins[14:12]; f7 = ins[31:25];
      if (o == 7'h13 && f == 0) return 0;
      if (o == 7'h33 && f == 0 && (f7 == 7'h00 || f7 == 7'h20)) return 0;
      if (o == 7'h63 && f == 0) return 1;
      if (o == 7'h6f) return 2;
      if (o == 7'h03 && f == 2) return 3;
      if (o == 7'h23 && f == 2) return 4;
      return 5;
   endfunction

   function automatic int exp_st();
      int c;
      c = cls_of(instr);
      if (m_trap) return 15;
      if (c == 5) return m_step;
      return sq[c][m_step];
   endfunction

   function automatic logic [14:0] exp_ctl(int s, logic [31:0] ins, logic z, logic rdy);
      logic mreq = 0, mwe = 0, io = 0, irw = 0, pcw = 0, pcs = 0, aop = 0, rwe = 0, ret = 0;
      logic [1:0] sa = 0, sb = 0, wb = 0;
      case (s)
         0: begin mreq = 1; sb = 1; if (rdy) begin irw = 1; pcw = 1; end end
         1: begin sa = 1; sb = 3; end
         2: begin sa = 2; sb = (ins[6:0] == 7'h13) ? 2 : 0;
                  aop = (ins[6:0] == 7'h33) && ins[30]; end
         3: begin rwe = 1; ret = 1; end
         4: begin sa = 2; aop = 1; ret = 1; if (z) begin pcw = 1; pcs = 1; end end
         5: begin rwe = 1; wb = 2; pcw = 1; pcs = 1; ret = 1; end
         6: begin sa = 2; sb = 2; end
         7: begin mreq = 1; io = 1; end
         8: begin mreq = 1; mwe = 1; io = 1; ret = rdy; end
         9: begin rwe = 1; wb = 1; ret = 1; end
         default: ;
      endcase
      return {mreq, mwe, io, irw, pcw, pcs, sa, sb, aop, rwe, wb, ret};
   endfunction

   // Called at posedge+1: drive, check mid-cycle, advance model, step clock.
   task automatic tick(input logic rdy, input logic z, output logic r, output logic we);
      int es, c;
      mem_ready = rdy; zero = z;
      #3;
      es = exp_st();
      c  = cls_of(instr);
      chk("state", 32'(state), es);
      chk("ctl", 32'(ctl), 32'(exp_ctl(es, instr, z, rdy)));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("bus_err", 32'(bus_err), 32'(m_berr));
      r = retire; we = reg_we;
      if (!m_trap) begin
         if (es == 0 || es == 7 || es == 8) begin
            if (rdy) begin
               m_wait = 0;
               m_step++;
               if (m_step == ln[c]) m_step = 0;
            end else begin
               m_wait++;
               if (m_wait == TMO) begin m_trap = 1; m_berr = 1; m_wait = 0; end
            end
         end else if (es == 1 && c == 5) begin
            m_trap = 1; m_ill = 1;
         end else begin
            m_step++;
            if (m_step == ln[c]) m_step = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; mem_ready = 1'b1;
      #3;
      chk("rst_state", 32'(state), 0);
      chk("rst_ctl", 32'(ctl), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      m_step = 0; m_wait = 0; m_trap = 0; m_ill = 0; m_berr = 0;
   endtask

   // Run one instruction; memory phases see wf / wm wait cycles before ready.
   task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                            output int cyc, output int nwe);
      int kf, km, es;
      logic rdy, r, we;
      bit done;
      instr = ins; kf = 0; km = 0; cyc = 0; nwe = 0; done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         es = exp_st();
         if (es == 0) begin rdy = (kf >= wf); kf++; end
         else if (es == 7 || es == 8) begin rdy = (km >= wm); km++; end
         else rdy = 1'($urandom);
         tick(rdy, z, r, we);
         cyc++; nwe += int'(we);
         if (r || m_trap) done = 1;
      end
      if (!done) chk("run_bound", 0, 1);
   endtask

   function automatic logic [31:0] gen(int c);
      logic [31:0] r;
      r = $urandom;
      case (c)
         0: if ($urandom % 2 == 0) r = {r[31:15], 3'b000, r[11:7], 7'h13};
            else r = {($urandom % 2 == 0) ? 7'h20 : 7'h00, r[24:15], 3'b000, r[11:7], 7'h33};
         1: r = {r[31:15], 3'b000, r[11:7], 7'h63};
         2: r = {r[31:7], 7'h6f};
         3: r = {r[31:15], 3'b010, r[11:7], 7'h03};
         4: r = {r[31:15], 3'b010, r[11:7], 7'h23};
         default: case ($urandom % 4)
            0: r = 32'h00001073;
            1: r = {r[31:15], 3'b001, r[11:7], 7'h13};
            2: r = {7'h01, r[24:15], 3'b000, r[11:7], 7'h33};
            default: r = {r[31:15], 3'b000, r[11:7], 7'h03};
         endcase
      endcase
      return r;
   endfunction

   initial begin
      int cyc, nwe, c, wf, wm;
      logic r, we;
      rstn = 1'b0; instr = 32'h00500093; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();

      run_instr(32'h00500093, 0, 0, 0, cyc, nwe); chk("addi_lat", cyc, 4);
      run_instr(32'h0000A103, 3, 3, 0, cyc, nwe); chk("lw_lat", cyc, 11);
      chk("lw_regwe", nwe, 1);
      run_instr(32'h00000063, 0, 0, 1, cyc, nwe); chk("beq_t_lat", cyc, 3);
      run_instr(32'h00000063, 0, 0, 0, cyc, nwe); chk("beq_nt_lat", cyc, 3);
      run_instr(32'h000000EF, 0, 0, 0, cyc, nwe); chk("jal_lat", cyc, 3);
      run_instr(32'h402081B3, 0, 0, 0, cyc, nwe); chk("sub_lat", cyc, 4);
      run_instr(32'h002081B3, 1, 0, 0, cyc, nwe); chk("add_lat", cyc, 5);
      run_instr(32'h0020A023, 0, 2, 0, cyc, nwe); chk("sw_lat", cyc, 6);

      run_instr(32'h00001073, 0, 0, 0, cyc, nwe);
      chk("sys_illegal", 32'(illegal), 1);
      for (int i = 0; i < 20; i++) tick(1'($urandom), 1'($urandom), r, we);
      do_reset();

      run_instr(32'h00500093, TMO, 0, 0, cyc, nwe);
      chk("tmo_cycles", cyc, TMO);
      chk("tmo_bus_err", 32'(bus_err), 1);
      do_reset();
      run_instr(32'h00500093, TMO - 1, 0, 0, cyc, nwe); chk("tmo_edge_lat", cyc, 4 + TMO - 1);
      run_instr(32'h0000A103, 0, TMO, 0, cyc, nwe);
      chk("rd_tmo_bus_err", 32'(bus_err), 1);
      do_reset();

      instr = 32'h00500093;
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, r, we);
      do_reset();
      run_instr(32'h00500093, TMO - 1, 0, 0, cyc, nwe); chk("rst_cnt_lat", cyc, 4 + TMO - 1);

      for (int n = 0; n < 60; n++) begin
         c  = ($urandom % 8 == 0) ? 5 : int'($urandom % 5);
         wf = ($urandom % 16 == 0) ? TMO : int'($urandom % 4);
         wm = (c == 3 || c == 4) ? (($urandom % 16 == 0) ? TMO : int'($urandom % 4)) : 0;
         run_instr(gen(c), wf, wm, 1'($urandom), cyc, nwe);
         if (m_trap) begin
            for (int i = 0; i < 3; i++) tick(1'($urandom), 1'($urandom), r, we);
            do_reset();
         end else begin
            chk("rand_lat", cyc, ln[c] + wf + wm);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
